muxn_rr: RTL and testbench

- Parametrised successor to the two-input select mux: NUM_CH-input multiplexer with per-channel valid/ready handshake and a registered output stage.
- Two modes: static select (channel chosen by sel_i, as the legacy mux) and round-robin arbitration across all requesting channels.
- Sits between the PE-array data sources (e.g. psum/iact streams) and a shared consumer such as the router or GLB write port.

---
 rtl/muxn_rr_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 60 ++++++
 rtl/muxn_rr.sv | 115 +++++++++++
 tb/tb_muxn_rr.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_rr_pkg.sv
// Shared constants and helpers for the N-input round-robin/static mux.
package muxn_rr_pkg;

  localparam logic MUXN_MODE_STATIC = 1'b0;
  localparam logic MUXN_MODE_RR     = 1'b1;

  // Index width for n items, never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) < n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: searches from the pointer upward, wraps at NUM_CH-1.
module rr_arbiter
  import muxn_rr_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W  = sel_width(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  input  logic              adv_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int unsigned      cand;

  // First requester at or after the pointer, with wrap-around.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!found && (j == cand) && req_i[j]) begin
          found = 1'b1;
          idx_o = IDX_W'(j);
        end
      end
    end
  end

  // One-hot grant, only while the consumer side can take a word.
  always_comb begin
    gnt_o = '0;
    for (int unsigned j = 0; j < NUM_CH; j++) begin
      gnt_o[j] = found && en_i && (idx_o == IDX_W'(j));
    end
  end

  // Pointer moves just past the winner once its word is accepted.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = (32'(idx_o) == (NUM_CH - 1)) ? '0 : idx_o + IDX_W'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/muxn_rr.sv
// NUM_CH-input mux with valid/ready per channel, static or round-robin
// selection, and a single registered output stage.
module muxn_rr
  import muxn_rr_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 20,
  parameter  int unsigned NUM_CH     = 4,
  localparam int unsigned SEL_WIDTH  = sel_width(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         mode_i,
  input  logic [SEL_WIDTH-1:0]         sel_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  input  logic [NUM_CH-1:0]            valid_i,
  output logic [NUM_CH-1:0]            ready_o,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [SEL_WIDTH-1:0]         ch_o
);

  logic                  rr_mode;
  logic                  load_en;
  logic                  static_ok;
  logic                  xfer_in;
  logic [SEL_WIDTH-1:0]  static_g;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [SEL_WIDTH-1:0]  rr_idx;
  logic [NUM_CH-1:0]     rr_gnt;
  logic [NUM_CH-1:0]     ready_c;
  logic [DATA_WIDTH-1:0] data_sel;

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [SEL_WIDTH-1:0]  ch_q,    ch_d;

  assign rr_mode = (mode_i == MUXN_MODE_RR);
  assign load_en = !valid_q || ready_i;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (valid_i),
    .en_i  (rr_mode && load_en && !rst_i),
    .adv_i (rr_mode && xfer_in),
    .gnt_o (rr_gnt),
    .idx_o (rr_idx)
  );

  // Static selection; a single-channel build always targets channel 0.
  always_comb begin
    static_g  = sel_i;
    static_ok = (32'(sel_i) < NUM_CH);
    if (NUM_CH == 1) begin
      static_g  = '0;
      static_ok = 1'b1;
    end
  end

  // Per-channel ready: independent of the held word, only of load_en.
  always_comb begin
    ready_c = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (rr_mode) ready_c[k] = rr_gnt[k];
      else         ready_c[k] = static_ok && load_en && !rst_i && (static_g == SEL_WIDTH'(k));
    end
  end

  assign grant_idx = rr_mode ? rr_idx : static_g;
  assign xfer_in   = |(ready_c & valid_i);
  assign ready_o   = ready_c;

  // Data mux for the granted channel.
  always_comb begin
    data_sel = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (grant_idx == SEL_WIDTH'(k)) data_sel = data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output stage next state: load on accept, clear valid on a pure drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    if (xfer_in) begin
      valid_d = 1'b1;
      data_d  = data_sel;
      ch_d    = grant_idx;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Output register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ch_o    = ch_q;

endmodule

// File: tb/tb_muxn_rr.sv
// Directed bench for muxn_rr: 4-channel main instance plus 6- and 3-channel builds.
module tb_muxn_rr;

  logic clk;
  logic rst;

  // 4-channel instance
  logic        mode4;
  logic [1:0]  sel4;
  logic [79:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  ready_o4;
  logic [19:0] data_o4;
  logic        valid_o4;
  logic        ready_i4;
  logic [1:0]  ch_o4;

  // 6-channel instance (static mode)
  logic         mode6;
  logic [2:0]   sel6;
  logic [119:0] data6;
  logic [5:0]   valid6;
  logic [5:0]   ready_o6;
  logic [19:0]  data_o6;
  logic         valid_o6;
  logic         ready_i6;
  logic [2:0]   ch_o6;

  // 3-channel instance (round-robin)
  logic        mode3;
  logic [1:0]  sel3;
  logic [59:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ready_o3;
  logic [19:0] data_o3;
  logic        valid_o3;
  logic        ready_i3;
  logic [1:0]  ch_o3;

  int n_checks;
  int n_fail;

  muxn_rr #(.DATA_WIDTH(20), .NUM_CH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode4), .sel_i(sel4), .data_i(data4),
    .valid_i(valid4), .ready_o(ready_o4), .data_o(data_o4), .valid_o(valid_o4),
    .ready_i(ready_i4), .ch_o(ch_o4)
  );

  muxn_rr #(.DATA_WIDTH(20), .NUM_CH(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode6), .sel_i(sel6), .data_i(data6),
    .valid_i(valid6), .ready_o(ready_o6), .data_o(data_o6), .valid_o(valid_o6),
    .ready_i(ready_i6), .ch_o(ch_o6)
  );

  muxn_rr #(.DATA_WIDTH(20), .NUM_CH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode3), .sel_i(sel3), .data_i(data3),
    .valid_i(valid3), .ready_o(ready_o3), .data_o(data_o3), .valid_o(valid_o3),
    .ready_i(ready_i3), .ch_o(ch_o3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    n_checks = 0;
    n_fail   = 0;

    rst      = 1'b1;
    mode4    = 1'b1;
    sel4     = 2'd0;
    valid4   = 4'hF;
    ready_i4 = 1'b1;
    for (int k = 0; k < 4; k++) data4[k*20 +: 20] = 20'hA0000 + 20'(k);

    mode6    = 1'b0;
    sel6     = 3'd5;
    valid6   = 6'b100000;
    ready_i6 = 1'b1;
    for (int k = 0; k < 6; k++) data6[k*20 +: 20] = 20'h60000 + 20'(k);
    data6[5*20 +: 20] = 20'h12345;

    mode3    = 1'b1;
    sel3     = 2'd0;
    valid3   = 3'b111;
    ready_i3 = 1'b1;
    for (int k = 0; k < 3; k++) data3[k*20 +: 20] = 20'h30000 + 20'(k);

    // Reset with every channel requesting
    #1;
    chk("rst_ready_pre", 32'(ready_o4), 32'h0);
    repeat (2) begin
      tick();
      chk("rst_valid", 32'(valid_o4), 32'h0);
      chk("rst_data",  32'(data_o4),  32'h0);
      chk("rst_ch",    32'(ch_o4),    32'h0);
      chk("rst_ready", 32'(ready_o4), 32'h0);
    end
    rst = 1'b0;

    // Round-robin fairness, back-to-back; NUM_CH=3 wraps 2->0
    for (int i = 0; i < 8; i++) begin
      if (i == 1) sel6 = 3'd6;
      #1;
      chk("rr_ready", 32'(ready_o4), 32'(1) << (i % 4));
      if (i == 0) chk("st6_ready", 32'(ready_o6), 32'b100000);
      if (i == 1) chk("st6_oob_ready", 32'(ready_o6), 32'h0);
      tick();
      chk("rr_ch",    32'(ch_o4),    32'(i % 4));
      chk("rr_data",  32'(data_o4),  32'h000A0000 + 32'(i % 4));
      chk("rr_valid", 32'(valid_o4), 32'h1);
      chk("rr3_ch",   32'(ch_o3),    32'(i % 3));
      if (i == 0) begin
        chk("st6_data", 32'(data_o6), 32'h12345);
        chk("st6_ch",   32'(ch_o6),   32'h5);
      end
      if (i == 1) chk("st6_oob_valid", 32'(valid_o6), 32'h0);
    end

    // Backpressure: held word must stay put, no ready upstream
    ready_i4 = 1'b0;
    repeat (3) begin
      #1;
      chk("bp_ready", 32'(ready_o4), 32'h0);
      tick();
      chk("bp_ch",    32'(ch_o4),    32'h3);
      chk("bp_data",  32'(data_o4),  32'hA0003);
      chk("bp_valid", 32'(valid_o4), 32'h1);
    end
    ready_i4 = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_o4), 32'b0001);
    tick();
    chk("bp_release_ch",    32'(ch_o4),    32'h0);
    chk("bp_release_valid", 32'(valid_o4), 32'h1);
    chk("bp_release_data",  32'(data_o4),  32'hA0000);

    // Sparse requests: move pointer to 2, then only ch1/ch3
    valid4 = 4'b0010;
    #1;
    chk("sp_ready_pre", 32'(ready_o4), 32'b0010);
    tick();
    chk("sp_ch_pre", 32'(ch_o4), 32'h1);
    valid4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      e = ((i % 2) == 0) ? 3 : 1;
      #1;
      chk("sp_ready", 32'(ready_o4), 32'(1) << e);
      tick();
      chk("sp_ch", 32'(ch_o4), 32'(e));
    end

    // Mode switch while a word is held
    ready_i4 = 1'b0;
    valid4   = 4'hF;
    mode4    = 1'b0;
    sel4     = 2'd2;
    data4[2*20 +: 20] = 20'h0A5A5;
    #1;
    chk("ms_ready_hold", 32'(ready_o4), 32'h0);
    tick();
    chk("ms_hold_ch",   32'(ch_o4),   32'h1);
    chk("ms_hold_data", 32'(data_o4), 32'hA0001);
    ready_i4 = 1'b1;
    #1;
    chk("st_ready", 32'(ready_o4), 32'b0100);
    tick();
    chk("st_data",  32'(data_o4),  32'h0A5A5);
    chk("st_ch",    32'(ch_o4),    32'h2);
    chk("st_valid", 32'(valid_o4), 32'h1);

    // Static select on an idle channel: drain only
    sel4   = 2'd3;
    valid4 = 4'b0010;
    #1;
    chk("st_idle_ready", 32'(ready_o4), 32'b1000);
    tick();
    chk("st_idle_valid", 32'(valid_o4), 32'h0);
    chk("st_idle_data",  32'(data_o4),  32'h0A5A5);
    chk("st_idle_ch",    32'(ch_o4),    32'h2);

    // Back to round-robin: pointer kept its value (2)
    mode4  = 1'b1;
    valid4 = 4'hF;
    #1;
    chk("rr_resume_ready", 32'(ready_o4), 32'b0100);
    tick();
    chk("rr_resume_ch", 32'(ch_o4), 32'h2);

    // Reset while a word is held
    ready_i4 = 1'b0;
    rst      = 1'b1;
    #1;
    chk("mrst_ready", 32'(ready_o4), 32'h0);
    tick();
    chk("mrst_valid", 32'(valid_o4), 32'h0);
    chk("mrst_data",  32'(data_o4),  32'h0);
    chk("mrst_ch",    32'(ch_o4),    32'h0);
    rst      = 1'b0;
    ready_i4 = 1'b1;
    #1;
    chk("mrst_first_ready", 32'(ready_o4), 32'b0001);
    tick();
    chk("mrst_first_ch",   32'(ch_o4),   32'h0);
    chk("mrst_first_data", 32'(data_o4), 32'hA0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
